// File: rtl/frame_buf_sched_pkg.sv
// rtl/frame_buf_sched_pkg.sv - shared encodings for the frame buffer ping-pong scheduler
// Contents:
//   wr_state_t          writer FSM encoding (W_IDLE, W_FILL)
//   rd_state_t          reader FSM encoding (R_IDLE, R_READ, R_DRAIN)
//   GRANT_WR/GRANT_RD   arbiter grant identifiers
//   ASSERT_N/DEASSERT_N levels for the active-low memory enables
`ifndef ASSERT_N
`define ASSERT_N 1'b0
`endif
`ifndef DEASSERT_N
`define DEASSERT_N 1'b1
`endif

package frame_buf_sched_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_READ  = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_t;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/frame_buf_rr_arb.sv
// rtl/frame_buf_rr_arb.sv - two-requester round-robin arbiter for the data memory port
// Ports:
//   wr_clk, reset   clock, synchronous active-high reset
//   wr_req, rd_req  write / read candidates this cycle
//   wr_gnt, rd_gnt  combinational one-hot (or zero) grant
module frame_buf_rr_arb
  import frame_buf_sched_pkg::*;
(
  input  logic wr_clk,
  input  logic reset,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);

  logic last_grant;

  // On contention the side that did not win last time gets the port.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (wr_req && rd_req) begin
      if (last_grant == GRANT_RD) wr_gnt = 1'b1;
      else                        rd_gnt = 1'b1;
    end else begin
      wr_gnt = wr_req;
      rd_gnt = rd_req;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset)       last_grant <= GRANT_RD;
    else if (wr_gnt) last_grant <= GRANT_WR;
    else if (rd_gnt) last_grant <= GRANT_RD;
  end

endmodule

// File: rtl/frame_buf_sched.sv
// rtl/frame_buf_sched.sv - ping-pong two-bank scheduler for the single-port frame memory
// Optional feature macro: FRAME_BUF_SCHED_DROP_CNT_EN (adds drop_cnt[15:0]).
// Ports:
//   wr_clk, reset                       clock, synchronous active-high reset
//   wr_sof, wr_valid, wr_data           capture side: frame start pulse and words
//   wr_ready, wr_busy                   word accepted this cycle / no free bank
//   rd_sof, rd_req                      display side: frame request, next-word request
//   rd_valid, rd_data, rd_eof           read word (1 cycle after grant), last-word flag
//   frame_avail                         a full bank not being read exists
//   mem_wr_en_n, mem_rd_en_n, mem_addr  memory controls, address {bank, word}
//   mem_wr_data, mem_rd_data            memory data out / in (1-cycle read latency)
//   drop_cnt                            count of ignored wr_sof (macro builds only)
module frame_buf_sched
  import frame_buf_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  wr_sof,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_busy,
  input  logic                  rd_sof,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_eof,
  output logic                  frame_avail,
  output logic                  mem_wr_en_n,
  output logic                  mem_rd_en_n,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [1:0]            full, full_nxt, free, avail;
  logic                  wbank, rbank, oldest;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                  reading, any_free, free_sel, rd_sel;
  logic                  wr_start, rd_start, wr_done, rd_done, rd_release;
  logic                  wr_cand, rd_cand, wr_gnt, rd_gnt;

  // A bank held by a non-idle reader is neither writable nor offered again.
  always_comb begin
    reading  = (rd_state != R_IDLE);
    free[0]  = !full[0] && !(reading && !rbank);
    free[1]  = !full[1] && !(reading &&  rbank);
    avail[0] =  full[0] && !(reading && !rbank);
    avail[1] =  full[1] && !(reading &&  rbank);
    any_free = |free;
    free_sel = !free[0];
    // Both banks offered only when both are full: take the older one.
    rd_sel   = (&avail) ? oldest : avail[1];
  end

  always_comb begin
    wr_start   = (wr_state == W_IDLE) && wr_sof && any_free;
    rd_start   = (rd_state == R_IDLE) && rd_sof && frame_avail;
    wr_done    = wr_gnt && (wr_cnt == LAST_WORD);
    rd_done    = rd_gnt && (rd_cnt == LAST_WORD);
    rd_release = (rd_state == R_DRAIN);
    full_nxt   = full;
    if (wr_done)    full_nxt[wbank] = 1'b1;
    if (rd_release) full_nxt[rbank] = 1'b0;
  end

  // FSM state registers
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_start) wr_state_nxt = W_FILL;
      W_FILL:  if (wr_done)  wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_start) rd_state_nxt = R_READ;
      R_READ:  if (rd_done)  rd_state_nxt = R_DRAIN;
      R_DRAIN: rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // FSM outputs; no memory op is issued while reset is held.
  always_comb begin
    wr_cand     = !reset && (wr_state == W_FILL) && wr_valid;
    rd_cand     = !reset && (rd_state == R_READ) && rd_req;
    wr_busy     = (wr_state == W_IDLE) && !any_free;
    frame_avail = |avail;
  end

  frame_buf_rr_arb u_arb (
    .wr_clk (wr_clk),
    .reset  (reset),
    .wr_req (wr_cand),
    .rd_req (rd_cand),
    .wr_gnt (wr_gnt),
    .rd_gnt (rd_gnt)
  );

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      full     <= 2'b00;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      oldest   <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_eof   <= 1'b0;
    end else begin
      full     <= full_nxt;
      rd_valid <= rd_gnt;
      rd_eof   <= rd_done;
      if (wr_start) begin
        wbank  <= free_sel;
        wr_cnt <= '0;
      end else if (wr_gnt) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_start) begin
        rbank  <= rd_sel;
        rd_cnt <= '0;
      end else if (rd_gnt) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      // The other bank is older only if it stays full past this cycle.
      if (wr_done) oldest <= full_nxt[~wbank] ? ~wbank : wbank;
    end
  end

  always_comb begin
    wr_ready    = wr_gnt;
    mem_wr_en_n = wr_gnt ? `ASSERT_N : `DEASSERT_N;
    mem_rd_en_n = rd_gnt ? `ASSERT_N : `DEASSERT_N;
    mem_addr    = rd_gnt ? {rbank, rd_cnt} : {wbank, wr_cnt};
    mem_wr_data = wr_data;
    rd_data     = mem_rd_data;
  end

`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
  always_ff @(posedge wr_clk) begin
    if (reset) drop_cnt <= 16'h0000;
    else if (wr_sof && (wr_busy || (wr_state == W_FILL)) && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb/tb_frame_buf_sched.sv - directed self-checking bench for frame_buf_sched
module tb_frame_buf_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_sof, wr_valid, wr_ready, wr_busy;
  logic [31:0] wr_data;
  logic        rd_sof, rd_req, rd_valid, rd_eof, frame_avail;
  logic [31:0] rd_data;
  logic        mem_wr_en_n, mem_rd_en_n;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  frame_buf_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .wr_clk      (clk),
    .reset       (reset),
    .wr_sof      (wr_sof),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_busy     (wr_busy),
    .rd_sof      (rd_sof),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_eof      (rd_eof),
    .frame_avail (frame_avail),
    .mem_wr_en_n (mem_wr_en_n),
    .mem_rd_en_n (mem_rd_en_n),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  // Single-port memory with 1-cycle read latency
  always @(posedge clk) begin
    if (!mem_wr_en_n) mem[mem_addr] <= mem_wr_data;
    if (!mem_rd_en_n) mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_frame(input logic bank, input logic [31:0] base);
    @(negedge clk);
    wr_sof = 1'b1; wr_valid = 1'b0;
    #1 chk("wsof_ready", wr_ready, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_sof = 1'b0; wr_valid = 1'b1; wr_data = base + i;
      #1;
      chk("w_ready", wr_ready, 1);
      chk("w_addr", mem_addr, {bank, i[2:0]});
      chk("w_en_n", mem_wr_en_n, 0);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1 chk("w_avail", frame_avail, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic prev_rd;
    int   prev_idx, wi, ri;
    reset = 1'b1; wr_sof = 0; wr_valid = 0; wr_data = 0; rd_sof = 0; rd_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_eof", rd_eof, 0);
    chk("rst_avail", frame_avail, 0);
    chk("rst_wr_en_n", mem_wr_en_n, 1);
    chk("rst_rd_en_n", mem_rd_en_n, 1);
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 0);
`endif

    // 1: one frame into bank 0
    write_frame(1'b0, 32'h100);
    chk("t1_busy", wr_busy, 0);

    // 2: read it back
    @(negedge clk);
    rd_sof = 1'b1;
    #1 chk("t2_sof_en", mem_rd_en_n, 1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rd_sof = 1'b0; rd_req = (i < 8);
      #1;
      if (i < 8) begin
        chk("t2_rd_en_n", mem_rd_en_n, 0);
        chk("t2_addr", mem_addr, {1'b0, i[2:0]});
      end
      if (i > 0) begin
        chk("t2_valid", rd_valid, 1);
        chk("t2_data", rd_data, 32'h100 + i - 1);
        chk("t2_eof", rd_eof, (i == 8));
      end else begin
        chk("t2_valid0", rd_valid, 0);
      end
    end
    @(negedge clk);
    #1;
    chk("t2_valid_end", rd_valid, 0);
    chk("t2_avail_end", frame_avail, 0);

    // 3: bank 0 refilled, then write bank 1 while reading bank 0
    write_frame(1'b0, 32'h200);
    @(negedge clk);
    wr_sof = 1'b1; rd_sof = 1'b1;
    #1 chk("t3_sof_idle", {mem_wr_en_n, mem_rd_en_n}, 2'b11);
    prev_rd = 1'b0; prev_idx = 0; wi = 0; ri = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      wr_sof = 1'b0; rd_sof = 1'b0;
      wr_valid = (wi < 8); rd_req = (ri < 8); wr_data = 32'h300 + wi;
      #1;
      chk("t3_valid", rd_valid, prev_rd);
      if (prev_rd) begin
        chk("t3_data", rd_data, 32'h200 + prev_idx);
        chk("t3_eof", rd_eof, (prev_idx == 7));
      end
      prev_rd = 1'b0;
      if (k < 16) begin
        // last grant before this phase was a write, so reads lead
        if (k % 2 == 0) begin
          chk("t3_rd_en_n", {mem_rd_en_n, mem_wr_en_n}, 2'b01);
          chk("t3_rd_addr", mem_addr, {1'b0, ri[2:0]});
          prev_rd = 1'b1; prev_idx = ri; ri++;
        end else begin
          chk("t3_wr_en_n", {mem_rd_en_n, mem_wr_en_n}, 2'b10);
          chk("t3_wr_addr", mem_addr, {1'b1, wi[2:0]});
          wi++;
        end
      end
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("t3_beats", {wi[7:0], ri[7:0]}, 16'h0808);
    chk("t3_avail", frame_avail, 1);
    chk("t3_busy", wr_busy, 0);

    // 4: second frame fills bank 0; both full
    write_frame(1'b0, 32'h400);
    chk("t4_busy", wr_busy, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wr_sof = 1'b1;
      @(negedge clk);
      wr_sof = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD;
      #1;
      chk("t4_ready", wr_ready, 0);
      chk("t4_wr_en_n", mem_wr_en_n, 1);
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
      chk("t4_drop", drop_cnt, k + 1);
`endif
    end
    wr_valid = 1'b0;
    // bank 1 was filled first, so it is read first
    @(negedge clk);
    rd_sof = 1'b1;
    @(negedge clk);
    rd_sof = 1'b0; rd_req = 1'b1;
    #1;
    chk("t4_old_addr", mem_addr, 4'h8);
    chk("t4_old_en_n", mem_rd_en_n, 0);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    chk("t4_old_data", rd_data, 32'h300);
    chk("t4_busy2", wr_busy, 1);

    // 6: rd_sof with nothing available is ignored
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_sof = 1'b1;
    #1 chk("t6_avail", frame_avail, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_sof = 1'b0; rd_req = 1'b1;
      #1;
      chk("t6_rd_en_n", mem_rd_en_n, 1);
      chk("t6_valid", rd_valid, 0);
    end
    rd_req = 1'b0;

    // 5: reset after four beats discards the partial frame
    @(negedge clk);
    wr_sof = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_sof = 1'b0; wr_valid = 1'b1; wr_data = 32'hBAD0 + i;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr_valid = 1'b0;
    #1;
    chk("t5_avail", frame_avail, 0);
    chk("t5_busy", wr_busy, 0);
    chk("t5_valid", rd_valid, 0);
    chk("t5_en_n", {mem_wr_en_n, mem_rd_en_n}, 2'b11);
    chk("t5_ready", wr_ready, 0);
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
    chk("t5_drop", drop_cnt, 0);
`endif
    write_frame(1'b0, 32'h500);
    chk("t5_busy2", wr_busy, 0);
    @(negedge clk);
    rd_sof = 1'b1;
    @(negedge clk);
    rd_sof = 1'b0; rd_req = 1'b1;
    #1 chk("t5_rd_addr", mem_addr, 4'h0);
    @(negedge clk);
    rd_req = 1'b0;
    #1 chk("t5_rd_data", rd_data, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
